// File: rtl/sp_ram_bank_multi.sv
// Single-port RAM bank of NUM_MACROS 32x2048 SRAM macros with registered read-select mux.
// Define SP_RAM_BANK_CLEAR_EN to zero-fill all macros after reset before ready_o rises.
module sp_ram_bank_multi #(
   parameter int unsigned NUM_MACROS  = 2,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned MACRO_WORDS = 2048
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    en_i,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    rvalid_o,
   output logic                    err_o,
   output logic                    ready_o
);

   localparam int unsigned LocalW = $clog2(MACRO_WORDS);
   localparam int unsigned WordW  = ADDR_WIDTH - 2;
   localparam int unsigned BeW    = DATA_WIDTH / 8;

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("sp_ram_bank_multi: DATA_WIDTH must be 32");
   end
   if (NUM_MACROS < 1 || NUM_MACROS > 8) begin : g_bad_num_macros
      $error("sp_ram_bank_multi: NUM_MACROS must be 1..8");
   end
   if ((MACRO_WORDS & (MACRO_WORDS - 1)) != 0) begin : g_bad_macro_words
      $error("sp_ram_bank_multi: MACRO_WORDS must be a power of two");
   end
   if ((64'd1 << ADDR_WIDTH) < 64'(4 * MACRO_WORDS * NUM_MACROS)) begin : g_bad_addr_width
      $error("sp_ram_bank_multi: ADDR_WIDTH too small for NUM_MACROS macros");
   end

   // Address decode
   logic [WordW-1:0]  word;
   logic [WordW-1:0]  macro_idx;
   logic [LocalW-1:0] local_word;
   logic [2:0]        req_sel;
   logic              in_range;
   logic              accept;
   logic              unused_addr_lsb;

   assign word            = addr_i[ADDR_WIDTH-1:2];
   assign macro_idx       = word >> LocalW;
   assign local_word      = word[LocalW-1:0];
   assign in_range        = macro_idx < WordW'(NUM_MACROS);
   assign req_sel         = 3'(macro_idx);
   assign accept          = en_i & ready_o;
   assign unused_addr_lsb = ^addr_i[1:0];

   // Shared macro pins; only csb0 is per-macro
   logic [NUM_MACROS-1:0] m_csb;
   logic                  m_web;
   logic [BeW-1:0]        m_wmask;
   logic [LocalW-1:0]     m_addr;
   logic [DATA_WIDTH-1:0] m_din;
   logic [DATA_WIDTH-1:0] m_dout [NUM_MACROS];

`ifdef SP_RAM_BANK_CLEAR_EN
   typedef enum logic [0:0] {StClear, StDone} clr_state_e;

   clr_state_e        clr_state_q, clr_state_d;
   logic [LocalW-1:0] clr_cnt_q, clr_cnt_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         clr_state_q <= StClear;
         clr_cnt_q   <= '0;
      end else begin
         clr_state_q <= clr_state_d;
         clr_cnt_q   <= clr_cnt_d;
      end
   end

   always_comb begin
      clr_state_d = clr_state_q;
      clr_cnt_d   = clr_cnt_q;
      unique case (clr_state_q)
         StClear: begin
            clr_cnt_d = clr_cnt_q + LocalW'(1);
            if (clr_cnt_q == LocalW'(MACRO_WORDS - 1)) begin
               clr_state_d = StDone;
            end
         end
         StDone: begin
         end
      endcase
   end

   assign ready_o = (clr_state_q == StDone);
`else
   logic ready_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign ready_o = ready_q;
`endif

   always_comb begin
      m_web   = ~we_i;
      m_wmask = be_i;
      m_addr  = local_word;
      m_din   = wdata_i;
      m_csb   = '1;
      for (int m = 0; m < int'(NUM_MACROS); m++) begin
         if (accept && in_range && (req_sel == 3'(m))) begin
            m_csb[m] = 1'b0;
         end
      end
`ifdef SP_RAM_BANK_CLEAR_EN
      // Clear sequencer owns every macro until it finishes
      if (clr_state_q == StClear) begin
         m_csb   = '0;
         m_web   = 1'b0;
         m_wmask = '1;
         m_din   = '0;
         m_addr  = clr_cnt_q;
      end
`endif
   end

   // Response path: select is registered so back-to-back reads pick the right dout0
   logic       rvalid_q;
   logic       err_q;
   logic       rd_hit_q;
   logic [2:0] rd_sel_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rd_hit_q <= 1'b0;
         rd_sel_q <= '0;
      end else begin
         rvalid_q <= accept & ~we_i;
         err_q    <= accept & ~in_range;
         rd_hit_q <= accept & ~we_i & in_range;
         if (accept) begin
            rd_sel_q <= req_sel;
         end
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int m = 0; m < int'(NUM_MACROS); m++) begin
         if (rd_hit_q && (rd_sel_q == 3'(m))) begin
            rdata_o = m_dout[m];
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;

   // Behavioural equivalent of sky130_sram_8kbyte_1rw_32x2048_8 (1RW, registered dout0)
   for (genvar g = 0; g < int'(NUM_MACROS); g++) begin : g_macro
      logic [DATA_WIDTH-1:0] mem [MACRO_WORDS];
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk_i) begin
         if (!m_csb[g]) begin
            if (!m_web) begin
               for (int b = 0; b < int'(BeW); b++) begin
                  if (m_wmask[b]) begin
                     mem[m_addr][8*b +: 8] <= m_din[8*b +: 8];
                  end
               end
            end else begin
               dout_q <= mem[m_addr];
            end
         end
      end

      assign m_dout[g] = dout_q;
   end

endmodule

// File: tb/tb_sp_ram_bank_multi.sv
// Directed self-checking bench for sp_ram_bank_multi (NUM_MACROS=2), with or without clear.
`timescale 1ns/1ps
module tb_sp_ram_bank_multi;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        en = 1'b0;
   logic        we = 1'b0;
   logic [15:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  be = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef SP_RAM_BANK_CLEAR_EN
   localparam int ReadyEdges = 2048;
`else
   localparam int ReadyEdges = 1;
`endif
   localparam int Timeout = 5000;

   always #5 clk = ~clk;

   sp_ram_bank_multi #(
      .NUM_MACROS (2),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (16),
      .MACRO_WORDS(2048)
   ) dut (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .en_i    (en),
      .addr_i  (addr),
      .wdata_i (wdata),
      .we_i    (we),
      .be_i    (be),
      .rdata_o (rdata),
      .rvalid_o(rvalid),
      .err_o   (err),
      .ready_o (ready)
   );

   // One request cycle; on return (edge + 1) the response is visible
   task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] b);
      en    = 1'b1;
      we    = w;
      addr  = a;
      wdata = d;
      be    = b;
      @(posedge clk);
      #1;
      en = 1'b0;
      we = 1'b0;
   endtask

   task automatic wait_ready(output int edges);
      edges = 0;
      while (!ready && edges < Timeout) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      int edges;
      #1 rstn = 1'b0;
      #1;
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held: got %b expected 0", ready); end
      rstn = 1'b1;
      wait_ready(edges);
      n_checks++; if (edges != ReadyEdges) begin n_fail++; $display("FAIL ready_rise_edges: got %0d expected %0d", edges, ReadyEdges); end
   endtask

   task automatic test_clear;
`ifdef SP_RAM_BANK_CLEAR_EN
      access(1'b0, 16'h0000, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL clear_0000: rvalid=%b rdata=%h expected 1/00000000", rvalid, rdata); end
      access(1'b0, 16'h1FFC, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL clear_1ffc: rvalid=%b rdata=%h expected 1/00000000", rvalid, rdata); end
      access(1'b0, 16'h3FFC, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL clear_3ffc: rvalid=%b rdata=%h expected 1/00000000", rvalid, rdata); end
`endif
   endtask

   // Requests while not ready are dropped; with clear, also abort clear at word 1000
   task automatic test_reset_mid_clear;
      int edges;
      int bad;
      rstn = 1'b0;
      @(posedge clk);
      #1;
`ifdef SP_RAM_BANK_CLEAR_EN
      rstn = 1'b1;
      repeat (1000) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      n_checks++; if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL midclear_reset: ready=%b rvalid=%b err=%b rdata=%h expected 0/0/0/0", ready, rvalid, err, rdata);
      end
      @(posedge clk);
      #1;
`endif
      en   = 1'b1;
      we   = 1'b0;
      addr = 16'h4000;
      rstn = 1'b1;
      edges = 0;
      bad = 0;
      while (!ready && edges < Timeout) begin
         @(posedge clk);
         #1;
         edges++;
         if (rvalid !== 1'b0 || err !== 1'b0) bad++;
      end
      en = 1'b0;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_not_ready: got %0d strobes expected 0", bad); end
      n_checks++; if (edges != ReadyEdges) begin n_fail++; $display("FAIL rerelease_edges: got %0d expected %0d", edges, ReadyEdges); end
      @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL drop_tail: rvalid=%b err=%b expected 0/0", rvalid, err); end
   endtask

   task automatic test_reset_mid_read;
      int edges;
      access(1'b1, 16'h0008, 32'hCAFEF00D, 4'hF);
      access(1'b0, 16'h0008, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pre_reset_read: rvalid=%b rdata=%h expected 1/cafef00d", rvalid, rdata); end
      en   = 1'b1;
      addr = 16'h0008;
      #2 rstn = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b0;
      n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL reset_mid_read: rvalid=%b rdata=%h expected 0/00000000", rvalid, rdata); end
      #2 rstn = 1'b1;
      wait_ready(edges);
      n_checks++; if (edges != ReadyEdges) begin n_fail++; $display("FAIL mid_read_ready: got %0d expected %0d", edges, ReadyEdges); end
   endtask

   task automatic test_byte_enables;
      access(1'b1, 16'h0004, 32'h12345678, 4'hF);
      n_checks++; if (rvalid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL write_no_strobe: rvalid=%b err=%b expected 0/0", rvalid, err); end
      access(1'b1, 16'h2004, 32'hDEADBEEF, 4'hF);
      access(1'b1, 16'h2004, 32'h000000AA, 4'b0001);
      access(1'b0, 16'h2004, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'hDEADBEAA) begin n_fail++; $display("FAIL be_0001: rvalid=%b rdata=%h expected 1/deadbeaa", rvalid, rdata); end
      access(1'b1, 16'h2004, 32'h55667788, 4'b1010);
      access(1'b0, 16'h2004, 32'h0, 4'h0);
      n_checks++; if (rdata !== 32'h55AD77AA) begin n_fail++; $display("FAIL be_1010: got %h expected 55ad77aa", rdata); end
      access(1'b0, 16'h0004, 32'h0, 4'h0);
      n_checks++; if (rdata !== 32'h12345678) begin n_fail++; $display("FAIL macro0_word1: got %h expected 12345678", rdata); end
   endtask

   task automatic test_back_to_back;
      access(1'b1, 16'h0000, 32'h11111111, 4'hF);
      access(1'b1, 16'h2000, 32'h22222222, 4'hF);
      access(1'b1, 16'h3FFC, 32'hA5A55A5A, 4'hF);
      en   = 1'b1;
      we   = 1'b0;
      addr = 16'h0000;
      @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_first: rvalid=%b rdata=%h expected 1/11111111", rvalid, rdata); end
      addr = 16'h2000;
      @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_second: rvalid=%b rdata=%h expected 1/22222222", rvalid, rdata); end
      addr = 16'h3FFC;
      @(posedge clk);
      #1;
      n_checks++; if (rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL b2b_last_word: got %h expected a5a55a5a", rdata); end
      addr = 16'h0000;
      @(posedge clk);
      #1;
      en = 1'b0;
      n_checks++; if (rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_back: got %h expected 11111111", rdata); end
      @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL b2b_idle: rvalid=%b rdata=%h expected 0/00000000", rvalid, rdata); end
   endtask

   task automatic test_out_of_range;
      access(1'b0, 16'h2000, 32'h0, 4'h0);
      access(1'b0, 16'h4000, 32'h0, 4'h0);
      n_checks++; if (err !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL oor_read: err=%b rvalid=%b rdata=%h expected 1/1/00000000", err, rvalid, rdata);
      end
      access(1'b1, 16'h4000, 32'hBAD0BAD0, 4'hF);
      n_checks++; if (err !== 1'b1 || rvalid !== 1'b0) begin n_fail++; $display("FAIL oor_write: err=%b rvalid=%b expected 1/0", err, rvalid); end
      access(1'b0, 16'h0000, 32'h0, 4'h0);
      n_checks++; if (err !== 1'b0 || rdata !== 32'h11111111) begin n_fail++; $display("FAIL oor_m0_intact: err=%b rdata=%h expected 0/11111111", err, rdata); end
      access(1'b0, 16'h2000, 32'h0, 4'h0);
      n_checks++; if (rdata !== 32'h22222222) begin n_fail++; $display("FAIL oor_m1_intact: got %h expected 22222222", rdata); end
      access(1'b0, 16'hFFFC, 32'h0, 4'h0);
      n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL oor_top: err=%b rdata=%h expected 1/00000000", err, rdata); end
      @(posedge clk);
      #1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b expected 0", err); end
   endtask

   task automatic test_write_read_0010;
      access(1'b1, 16'h0010, 32'h0BADF00D, 4'hF);
      access(1'b0, 16'h0010, 32'h0, 4'h0);
      n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL rw_0010: rvalid=%b rdata=%h expected 1/0badf00d", rvalid, rdata); end
      @(posedge clk);
      #1;
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b expected 0", rvalid); end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_reset_mid_clear();
      test_reset_mid_read();
      test_byte_enables();
      test_back_to_back();
      test_out_of_range();
      test_write_read_0010();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
